// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter
// Round-robin arbiter that shares one wide combinational read mux among NREQ
// requesters. One read is accepted per cycle; the winning address is registered
// onto mux_sel_o, the mux output is captured one edge later and returned to the
// requester that issued it. A requester may lock the port for a burst of up to
// MAX_BURST consecutive reads.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   req_valid_i  per-requester read request
//   req_addr_i   per-requester read address
//   req_lock_i   per-requester burst lock, sampled when that request is accepted
//   req_ready_o  one-hot grant (accept = valid & ready)
//   mux_sel_o    registered select to the shared mux
//   mux_data_i   shared mux output, combinational from mux_sel_o
//   rsp_valid_o  one-hot, single-cycle response strobe
//   rsp_data_o   read data, meaningful while any rsp_valid_o bit is set
//   busy_o       locked, or a read is still in the pipeline
module mem_rd_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned AW        = 11,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [AW-1:0]   req_addr_i [0:NREQ-1],
    input  logic [NREQ-1:0] req_lock_i,
    output logic [NREQ-1:0] req_ready_o,
    output logic [AW-1:0]   mux_sel_o,
    input  logic [DW-1:0]   mux_data_i,
    output logic [NREQ-1:0] rsp_valid_o,
    output logic [DW-1:0]   rsp_data_o,
    output logic            busy_o
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } state_e;

    // Arbitration state
    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   lock_owner_q, lock_owner_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;

    // Issue stage
    logic            issue_v_q, issue_v_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [AW-1:0]   mux_sel_q, mux_sel_d;

    // Response stage
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;

    // Grant decision for the current cycle
    logic            grant_any;
    logic [IW-1:0]   grant_idx;
    logic [NREQ-1:0] grant_oh;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] k);
        return (k == IW'(NREQ - 1)) ? '0 : k + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Grant selection. In StIdle the search starts at ptr_q and wraps, so
    // the first valid index at or after the pointer wins. In StLocked only
    // the lock owner can be granted, and only when it is requesting.
    // ------------------------------------------------------------------
    always_comb begin
        logic [IW-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (state_q == StIdle) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                cand = IW'((32'(ptr_q) + i) % NREQ);
                if (!grant_any && req_valid_i[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end else begin
            if (req_valid_i[lock_owner_q]) begin
                grant_any = 1'b1;
                grant_idx = lock_owner_q;
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_any) begin
            grant_oh = NREQ'(1) << grant_idx;
        end
    end

    assign req_ready_o = grant_oh;

    // ------------------------------------------------------------------
    // Lock FSM and round-robin pointer.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        lock_owner_d = lock_owner_q;
        burst_cnt_d  = burst_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (grant_any) begin
                    ptr_d = wrap_inc(grant_idx);
                    if (req_lock_i[grant_idx]) begin
                        state_d      = StLocked;
                        lock_owner_d = grant_idx;
                        burst_cnt_d  = CW'(1);
                    end
                end
            end

            StLocked: begin
                if (!grant_any) begin
                    // Owner went quiet: give the port back this edge.
                    state_d     = StIdle;
                    ptr_d       = wrap_inc(lock_owner_q);
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    // Release on an unlocked accept, or when this accept
                    // completes the maximum burst length.
                    if (!req_lock_i[lock_owner_q] ||
                        (burst_cnt_q == CW'(MAX_BURST - 1))) begin
                        state_d     = StIdle;
                        ptr_d       = wrap_inc(lock_owner_q);
                        burst_cnt_d = '0;
                    end
                end
            end

            default: begin
                state_d     = StIdle;
                burst_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue and response pipeline. The mux select is registered so the
    // combinational mux sees a stable address for a full cycle; its output
    // is captured at the following edge.
    // ------------------------------------------------------------------
    always_comb begin
        issue_v_d = grant_any;
        owner_d   = owner_q;
        mux_sel_d = mux_sel_q;
        if (grant_any) begin
            owner_d   = grant_idx;
            mux_sel_d = req_addr_i[grant_idx];
        end
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (issue_v_q) begin
            rsp_valid_d = NREQ'(1) << owner_q;
            rsp_data_d  = mux_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            lock_owner_q <= '0;
            burst_cnt_q  <= '0;
            issue_v_q    <= 1'b0;
            owner_q      <= '0;
            mux_sel_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            lock_owner_q <= lock_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            issue_v_q    <= issue_v_d;
            owner_q      <= owner_d;
            mux_sel_q    <= mux_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign mux_sel_o   = mux_sel_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = (state_q == StLocked) | issue_v_q | (|rsp_valid_q);

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_ready_o));
    a_ready_needs_valid: assert property (@(posedge clk_i) disable iff (rst_i)
        (req_ready_o & ~req_valid_i) == '0);
    a_rsp_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(rsp_valid_o));
    a_locked_owner_only: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == StLocked) |-> ((req_ready_o & ~(NREQ'(1) << lock_owner_q)) == '0));
`endif

endmodule
